// File: rtl/rice_pkg.sv
// Shared types and helpers for the Rice residual writer and reader.
// Holds the FSM state set and the partition sample-count formula.
package rice_pkg;

    localparam int RICE_PARAM_BITS = 4;
    localparam int SAMPLE_W        = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PARAM,
        S_UNARY,
        S_STOP,
        S_REMAINDER
    } rice_state_t;

    // Samples in a partition; the first one loses the warm-up samples.
    function automatic logic [SAMPLE_W-1:0] rice_part_count(
        input logic [SAMPLE_W-1:0] block_size,
        input logic [3:0]          part_order,
        input logic [3:0]          pred_order,
        input logic                first
    );
        logic [SAMPLE_W-1:0] typical;
        typical = block_size >> part_order;
        return first ? typical - {12'd0, pred_order} : typical;
    endfunction

endpackage

// File: rtl/rice_stream_writer_if.sv
// Residual input and serial output handshakes of the Rice writer.
// slave is the writer side, master the producer/consumer side.
interface rice_stream_writer_if;
    import rice_pkg::*;

    logic                       iValid;
    logic                       oReady;
    logic [SAMPLE_W-1:0]        iResidual;
    logic [RICE_PARAM_BITS-1:0] iRiceParam;
    logic                       iOutReady;
    logic                       oData;
    logic                       oValid;
    logic                       oDone;

    modport slave (
        input  iValid, iResidual, iRiceParam, iOutReady,
        output oReady, oData, oValid, oDone
    );

    modport master (
        output iValid, iResidual, iRiceParam, iOutReady,
        input  oReady, oData, oValid, oDone
    );

endinterface

// File: rtl/rice_fold.sv
// Zigzag fold of a signed residual into an unsigned Rice value.
// u = (r << 1) ^ (r >>> 15): 0,-1,1,-2,... map to 0,1,2,3,...
module rice_fold
    import rice_pkg::*;
(
    input  logic [SAMPLE_W-1:0] r,
    output logic [SAMPLE_W-1:0] u
);

    assign u = (r << 1) ^ {SAMPLE_W{r[SAMPLE_W-1]}};

endmodule

// File: rtl/rice_stream_writer.sv
// Rice residual serializer: parameter, unary quotient, remainder, MSB first.
// Build option RICE_ZIGZAG_EN: fold signed residuals internally.
module rice_stream_writer
    import rice_pkg::*;
(
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iStart,
    input  logic [SAMPLE_W-1:0] iBlockSize,
    input  logic [3:0]          iPredictorOrder,
    input  logic [3:0]          iPartitionOrder,
    rice_stream_writer_if.slave bus
);

    rice_state_t state, next;

    logic [RICE_PARAM_BITS-1:0] k_q;
    logic [SAMPLE_W-1:0]        q_q;
    logic [SAMPLE_W-1:0]        rem_q;
    logic [3:0]                 bit_q;
    logic [SAMPLE_W-1:0]        sample_cnt;
    logic [SAMPLE_W-1:0]        part_idx;
    logic [SAMPLE_W-1:0]        first_cnt;
    logic [SAMPLE_W-1:0]        typ_cnt;
    logic [3:0]                 porder;

    logic [SAMPLE_W-1:0]        u;
    logic [RICE_PARAM_BITS-1:0] k_eff;
    logic [SAMPLE_W-1:0]        q_new;
    logic [SAMPLE_W-1:0]        rem_new;
    logic [SAMPLE_W-1:0]        part_cnt;
    logic [SAMPLE_W:0]          last_idx;
    logic                       first_sample;
    logic                       last_in_part;
    logic                       last_part;
    logic                       adv;
    logic                       sample_done;
    logic                       ready;
    logic                       valid;
    logic                       data;
    logic                       done;

`ifdef RICE_ZIGZAG_EN
    rice_fold u_fold (
        .r (bus.iResidual),
        .u (u)
    );
`else
    assign u = bus.iResidual;
`endif

    assign first_sample = sample_cnt == '0;
    assign k_eff        = first_sample ? bus.iRiceParam : k_q;
    assign q_new        = u >> k_eff;
    assign rem_new      = u & ((16'd1 << k_eff) - 16'd1);
    assign part_cnt     = (part_idx == '0) ? first_cnt : typ_cnt;
    assign last_idx     = (17'd1 << porder) - 17'd1;
    assign last_part    = {1'b0, part_idx} == last_idx;
    assign last_in_part = sample_cnt == part_cnt - 16'd1;
    assign adv          = bus.iOutReady;

    assign bus.oReady = ready;
    assign bus.oValid = valid;
    assign bus.oData  = data;
    assign bus.oDone  = done;

    // State register.
    always_ff @(posedge iClock) begin
        if (iReset) state <= S_IDLE;
        else        state <= next;
    end

    // Next state and serial outputs; bits advance only when accepted.
    always_comb begin
        next        = state;
        ready       = 1'b0;
        valid       = 1'b0;
        data        = 1'b0;
        sample_done = 1'b0;
        done        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (iStart) next = S_LOAD;
            end
            S_LOAD: begin
                ready = 1'b1;
                if (bus.iValid) begin
                    if (first_sample)     next = S_PARAM;
                    else if (q_new != '0) next = S_UNARY;
                    else                  next = S_STOP;
                end
            end
            S_PARAM: begin
                valid = 1'b1;
                data  = k_q[bit_q[1:0]];
                if (adv && bit_q == 4'd0)
                    next = (q_q != '0) ? S_UNARY : S_STOP;
            end
            S_UNARY: begin
                valid = 1'b1;
                if (adv && q_q == 16'd1) next = S_STOP;
            end
            S_STOP: begin
                valid = 1'b1;
                data  = 1'b1;
                if (adv) begin
                    if (k_q != '0) next = S_REMAINDER;
                    else           sample_done = 1'b1;
                end
            end
            S_REMAINDER: begin
                valid = 1'b1;
                data  = rem_q[bit_q];
                if (adv && bit_q == 4'd0) sample_done = 1'b1;
            end
            default: next = S_IDLE;
        endcase
        if (sample_done) begin
            if (last_in_part && last_part) begin
                done = 1'b1;
                next = S_IDLE;
            end else begin
                next = S_LOAD;
            end
        end
    end

    // Block config, per-sample fields and partition bookkeeping.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            k_q        <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            bit_q      <= '0;
            sample_cnt <= '0;
            part_idx   <= '0;
            first_cnt  <= '0;
            typ_cnt    <= '0;
            porder     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (iStart) begin
                        first_cnt  <= rice_part_count(iBlockSize,
                            iPartitionOrder, iPredictorOrder, 1'b1);
                        typ_cnt    <= rice_part_count(iBlockSize,
                            iPartitionOrder, iPredictorOrder, 1'b0);
                        porder     <= iPartitionOrder;
                        sample_cnt <= '0;
                        part_idx   <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.iValid) begin
                        q_q   <= q_new;
                        rem_q <= rem_new;
                        if (first_sample) begin
                            k_q   <= bus.iRiceParam;
                            bit_q <= 4'd3;
                        end
                    end
                end
                S_PARAM: begin
                    if (adv) bit_q <= bit_q - 4'd1;
                end
                S_UNARY: begin
                    if (adv) q_q <= q_q - 16'd1;
                end
                S_STOP: begin
                    if (adv && k_q != '0) bit_q <= k_q - 4'd1;
                end
                S_REMAINDER: begin
                    if (adv) bit_q <= bit_q - 4'd1;
                end
                default: ;
            endcase
            if (sample_done) begin
                if (last_in_part) begin
                    sample_cnt <= '0;
                    part_idx   <= part_idx + 16'd1;
                end else begin
                    sample_cnt <= sample_cnt + 16'd1;
                end
            end
        end
    end

endmodule
